// File: rtl/sram_controller_pkg.sv
// Shared constants and types for the 32-bit over 16-bit SRAM controller.
// Build option: SRAM_MISALIGN_CHECK_EN adds the misalignment error path.
package sram_controller_pkg;

    localparam int WORD_WIDTH          = 32;
    localparam int SRAM_DATA_WIDTH     = 16;
    localparam int DEF_SRAM_ADDR_WIDTH = 18;
    localparam int CNT_WIDTH           = 4;

    localparam logic [1:0] SRAM_IDLE = 2'd0;
    localparam logic [1:0] SRAM_LO   = 2'd1;
    localparam logic [1:0] SRAM_HI   = 2'd2;
    localparam logic [1:0] SRAM_DONE = 2'd3;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } sram_op_e;

    typedef struct packed {
        sram_op_e              op;
        logic [WORD_WIDTH-1:0] data;
    } sram_req_t;

    function automatic logic [SRAM_DATA_WIDTH-1:0] half_sel(
        input logic [WORD_WIDTH-1:0] word,
        input logic                  hi
    );
        return hi ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side request bus and SRAM pin bundle of the data-memory controller.
// Build option: SRAM_MISALIGN_CHECK_EN adds the err signal.
interface sram_controller_if #(
    parameter int AW = 18
);
    logic          wr_en;
    logic          rd_en;
    logic [31:0]   address;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;
    logic          sram_oe_n;
    logic          sram_ce_n;
    logic          sram_ub_n;
    logic          sram_lb_n;
`ifdef SRAM_MISALIGN_CHECK_EN
    logic          err;
`endif

    modport master (
`ifdef SRAM_MISALIGN_CHECK_EN
        input  err,
`endif
        output wr_en, rd_en, address, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe,
        input  sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
    );

    modport slave (
`ifdef SRAM_MISALIGN_CHECK_EN
        output err,
`endif
        input  wr_en, rd_en, address, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe,
        output sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one half-word phase; last marks its final cycle.
module sram_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic             last
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/sram_controller.sv
// Data-memory controller: 32-bit loads/stores as two wait-stated 16-bit phases.
// Build option: SRAM_MISALIGN_CHECK_EN rejects unaligned requests with err.
module sram_controller #(
    parameter int ADDR_BASE       = 1024,
    parameter int WAIT_CYCLES     = 2,
    parameter int SRAM_ADDR_WIDTH = 18
) (
    input logic              clk,
    input logic              rst,
    sram_controller_if.slave bus
);
    import sram_controller_pkg::*;

    localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(WAIT_CYCLES - 1);

    logic [1:0]                 state;
    logic [1:0]                 state_n;
    logic                       req;
    logic                       last;
    logic                       load;
    logic                       phase;
    logic                       phase_n;
    logic                       misaligned;
    sram_req_t                  cur;
    sram_req_t                  nxt;
    logic [SRAM_ADDR_WIDTH:0]   off;
    logic [SRAM_ADDR_WIDTH-2:0] base_in;
    logic [SRAM_ADDR_WIDTH-2:0] base_q;
    logic [SRAM_ADDR_WIDTH-2:0] nxt_base;
    logic [15:0]                rlo_q;
    logic [31:0]                rdata_q;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q;
    logic [15:0]                dq_out_q;
    logic                       dq_oe_q;
    logic                       we_n_q;
    logic                       oe_n_q;
    logic                       ce_n_q;
    logic                       unused_off;

    assign req        = bus.wr_en | bus.rd_en;
    assign off        = (SRAM_ADDR_WIDTH+1)'(bus.address - 32'(ADDR_BASE));
    assign base_in    = off[SRAM_ADDR_WIDTH:2];
    assign unused_off = &{1'b0, off[1:0]};
    assign phase      = (state == SRAM_LO) | (state == SRAM_HI);
    assign phase_n    = (state_n == SRAM_LO) | (state_n == SRAM_HI);
    assign load       = phase_n & (state_n != state);

`ifdef SRAM_MISALIGN_CHECK_EN
    logic err_q;
    assign misaligned = |bus.address[1:0];
    assign bus.err    = err_q;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            SRAM_IDLE: if (req) state_n = misaligned ? SRAM_DONE : SRAM_LO;
            SRAM_LO:   if (last) state_n = SRAM_HI;
            SRAM_HI:   if (last) state_n = SRAM_DONE;
            default:   state_n = SRAM_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so the pins never glitch.
    always_comb begin
        nxt      = cur;
        nxt_base = base_q;
        if (state == SRAM_IDLE) begin
            nxt.op   = bus.wr_en ? OP_WR : OP_RD;
            nxt.data = bus.wdata;
            nxt_base = base_in;
        end
    end

    sram_wait_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (phase),
        .value(RELOAD),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= SRAM_IDLE;
            cur    <= '0;
            base_q <= '0;
        end else begin
            state <= state_n;
            if (state == SRAM_IDLE && req) begin
                cur    <= nxt;
                base_q <= nxt_base;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            ce_n_q   <= 1'b1;
        end else begin
            dq_oe_q <= phase_n & (nxt.op == OP_WR);
            we_n_q  <= ~(phase_n & (nxt.op == OP_WR));
            oe_n_q  <= ~(phase_n & (nxt.op == OP_RD));
            ce_n_q  <= ~phase_n;
            if (phase_n) begin
                addr_q   <= {nxt_base, state_n == SRAM_HI};
                dq_out_q <= half_sel(nxt.data, state_n == SRAM_HI);
            end
        end
    end

    // The low half is parked so rdata changes only when the whole word lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rlo_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (state == SRAM_LO && last && cur.op == OP_RD) begin
                rlo_q <= bus.sram_dq_in;
            end
            if (state == SRAM_HI && last && cur.op == OP_RD) begin
                rdata_q <= {bus.sram_dq_in, rlo_q};
            end
            if (state == SRAM_IDLE && req && misaligned && !bus.wr_en) begin
                rdata_q <= '0;
            end
        end
    end

`ifdef SRAM_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == SRAM_IDLE) & req & misaligned;
        end
    end
`endif

    assign bus.ready       = ~req | (state == SRAM_DONE);
    assign bus.rdata       = rdata_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_ub_n   = ce_n_q;
    assign bus.sram_lb_n   = ce_n_q;

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side neighbour of the pipeline top. It sits between the EXE-stage pipeline register (`ALU_res`, `Val_Rm`, mem read/write enables) and the MEM-stage register. It serves 32-bit data-memory loads and stores from an external 16-bit asynchronous SRAM using a two-half-word, wait-stated FSM. While an access is in flight it drives `ready` low, and the top freezes every pipeline register on `~ready`.

## Interface
- `ADDR_BASE`, default 1024: data-memory base; the CPU byte address minus this value gives the SRAM byte offset.
- `WAIT_CYCLES`, default 2: cycles spent on each half-word phase; legal range is 1..15.
- `SRAM_ADDR_WIDTH`, default 18: width of the external half-word address.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `wr_en` in 1: store request, level; held while `ready` is low.
- `rd_en` in 1: load request, level.
- `address` in 32: CPU byte address (`ALU_res`).
- `wdata` in 32: store data (`Val_Rm`).
- `rdata` out 32: load result; valid when `ready` is high in DONE.
- `ready` out 1: access complete or no request; a low value freezes the pipeline.
- `sram_addr` out SRAM_ADDR_WIDTH: half-word address.
- `sram_dq_out` out 16: write data.
- `sram_dq_oe` out 1: drive enable for the DQ pad; the top-level pad owns the tristate.
- `sram_dq_in` in 16: read data from the pad.
- `sram_we_n`, `sram_oe_n`, `sram_ce_n`, `sram_ub_n`, `sram_lb_n` out 1 each: SRAM strobes, all active-low.
- `err` out 1: present only with `SRAM_MISALIGN_CHECK_EN`.

## Operation
- Address mapping:
  - `off = address - ADDR_BASE`, computed 32-bit and truncated.
  - Low half: `sram_addr = {off[SRAM_ADDR_WIDTH:2], 1'b0}`.
  - High half: `sram_addr = {off[SRAM_ADDR_WIDTH:2], 1'b1}`.
  - The low half-word sits at the even address.
- FSM states:
  - IDLE: when `wr_en|rd_en`, latch address, data and op (write wins if both are set), then go to LO.
  - LO: `WAIT_CYCLES` cycles on the low half, then go to HI.
  - HI: `WAIT_CYCLES` cycles on the high half, then go to DONE.
  - DONE: one cycle, then unconditionally back to IDLE.
- `ready = ~(wr_en|rd_en) | (state==DONE)`. This is combinational, so an idle pipeline never stalls.
- Reads:
  - `sram_oe_n=0` in LO and HI.
  - `sram_dq_in` is sampled on the last cycle of each phase into `rdata[15:0]` / `rdata[31:16]`.
  - `rdata` holds until the next read completes.
- Writes:
  - `sram_dq_oe=1` and `sram_we_n=0` in LO and HI.
  - `sram_dq_out` carries the latched `wdata[15:0]` / `[31:16]`.
  - `sram_we_n` returns high in DONE.
- Strobes:
  - `ce_n`, `ub_n`, `lb_n` are 0 in LO and HI, 1 otherwise.
  - `sram_addr` is held stable through each phase.
- Requests are sampled only in IDLE. A request that drops mid-access does not abort it; the access runs to DONE.
- Reset values:
  - state=IDLE, wait counter=0, `rdata=0`.
  - `we_n`, `oe_n`, `ce_n`, `ub_n`, `lb_n` = 1; `dq_oe=0`; `sram_addr=0`; `err=0`.
  - `ready` follows its combinational formula.
- Reset asserted mid-access abandons the access: next cycle is IDLE and strobes are released.

## Timing
- Request visible at cycle 0 (IDLE). LO covers cycles 1..W, HI covers W+1..2W, DONE is cycle 2W+1.
- `ready` is high in cycle 2W+1; the pipeline advances on that edge.
- Total stall is 2W+1 cycles per access: 5 cycles with the default W=2.
- A back-to-back request seen in the cycle after DONE starts a new access immediately.
- `WAIT_CYCLES=1` gives LO and HI one cycle each; the counter wraps 0→W-1.

## Configuration
- Macro `SRAM_MISALIGN_CHECK_EN`.
- Defined, when a request arrives in IDLE with `address[1:0]!=0`:
  - no SRAM strobe toggles;
  - the FSM goes IDLE→DONE;
  - `ready` goes high the next cycle;
  - `err` pulses high for exactly that DONE cycle;
  - a read returns `rdata=0`.
- Undefined: `address[1:0]` is ignored and there is no `err` port.

## Structure
- `constants.h` gets `SRAM_DATA_WIDTH` (16), `SRAM_ADDR_WIDTH` (18) and the state encodings `SRAM_IDLE`/`SRAM_LO`/`SRAM_HI`/`SRAM_DONE`, alongside `WORD_WIDTH`.
- One sub-module, `sram_wait_counter`: a loadable down-counter with a `last` flag that marks the end of each phase.

## Test plan
- No request:
  - `ready`=1, all strobes high, across 10 cycles.
- Store then load round trip:
  - `wr_en`, address 1024, `wdata`=0xDEADBEEF.
  - SRAM model holds 0xBEEF at 0 and 0xDEAD at 1.
  - `ready` is low cycles 0–4 and high in cycle 5.
  - Load of 1024 returns `rdata`=0xDEADBEEF in DONE.
- Address 1032:
  - `sram_addr` is 4 then 5.
  - A simultaneous `rd_en|wr_en` performs the write.
- Back-to-back loads at 1024 and 1028:
  - two 5-cycle stalls with no idle gap;
  - correct data each time.
- Reset mid-access:
  - `rst`=0 in HI of a store.
  - Next cycle: IDLE, `we_n`=1, `dq_oe`=0, address 1 untouched.
- Misalignment, with `SRAM_MISALIGN_CHECK_EN` defined:
  - load of 1026 gives `err`=1 and `ready`=1 at cycle 1, `rdata`=0, no strobes.
  - Without the macro, the same load reads half-words 0 and 1.
